// File: rtl/snake_pkg.sv
// Shared food-placement constants: play grid, field bounds, coordinate widths, reset food position, FSM encoding.
package snake_pkg;
    localparam int XW         = 10;
    localparam int YW         = 9;
    localparam int GRID       = 20;
    localparam int X_MIN      = 20;
    localparam int X_MAX      = 600;
    localparam int Y_MIN      = 20;
    localparam int Y_MAX      = 440;
    localparam int MAX_LEN    = 64;
    localparam int MAX_RETRY  = 15;
    localparam int FOOD_X_RST = 300;
    localparam int FOOD_Y_RST = 200;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        SCAN,
        DONE
    } state_t;
endpackage

// File: rtl/grid_snap.sv
// Combinational floor-to-GRID then clamp to [LO, HI]; zero latency, no flow control.
module grid_snap #(
    parameter int W    = 10,
    parameter int GRID = 20,
    parameter int LO   = 20,
    parameter int HI   = 600
) (
    input  logic [W-1:0] raw,
    output logic [W-1:0] snapped
);
    logic [W-1:0] floored;

    always_comb begin
        floored = raw - W'(raw % W'(GRID));
        snapped = floored;
        if (floored < W'(LO)) begin
            snapped = W'(LO);
        end else if (floored > W'(HI)) begin
            snapped = W'(HI);
        end
    end
endmodule

// File: rtl/food_placer.sv
// Samples a snapped random candidate and scans the snake body RAM until a free cell is found; L+4 edges per clean try.
// No queueing: place_req while busy is dropped; gives up with sticky place_fail after MAX_RETRY colliding tries.
module food_placer
    import snake_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [XW-1:0] rand_x,
    input  logic [YW-1:0] rand_y,
    input  logic          place_req,
    input  logic [6:0]    snake_len,
    output logic [5:0]    seg_idx,
    input  logic [XW-1:0] seg_x,
    input  logic [YW-1:0] seg_y,
    output logic [XW-1:0] food_x,
    output logic [YW-1:0] food_y,
    output logic          food_valid,
    output logic          busy,
    output logic          place_fail
);
    state_t        state;
    logic [XW-1:0] snap_x, cand_x;
    logic [YW-1:0] snap_y, cand_y;
    logic [6:0]    len;
    logic [3:0]    attempt;
    logic          iss;      // a RAM read is being issued this cycle
    logic          rd_vld;   // seg_x/seg_y carry an issued read this cycle
    logic          rd_last;  // that read was segment len-1
    logic          last_iss;
    logic          hit;

    grid_snap #(.W(XW), .GRID(GRID), .LO(X_MIN), .HI(X_MAX)) u_snap_x (
        .raw     (rand_x),
        .snapped (snap_x)
    );

    grid_snap #(.W(YW), .GRID(GRID), .LO(Y_MIN), .HI(Y_MAX)) u_snap_y (
        .raw     (rand_y),
        .snapped (snap_y)
    );

    assign last_iss = ({1'b0, seg_idx} == (len - 7'd1));
    assign hit      = rd_vld && (seg_x == cand_x) && (seg_y == cand_y);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            food_x     <= XW'(FOOD_X_RST);
            food_y     <= YW'(FOOD_Y_RST);
            food_valid <= 1'b0;
            busy       <= 1'b0;
            place_fail <= 1'b0;
            seg_idx    <= '0;
            cand_x     <= '0;
            cand_y     <= '0;
            len        <= '0;
            attempt    <= '0;
            iss        <= 1'b0;
            rd_vld     <= 1'b0;
            rd_last    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (place_req) begin
                        state      <= SAMPLE;
                        busy       <= 1'b1;
                        food_valid <= 1'b0;
                        place_fail <= 1'b0;
                        attempt    <= '0;
                        seg_idx    <= '0;
                    end
                end
                SAMPLE: begin
                    cand_x  <= snap_x;
                    cand_y  <= snap_y;
                    len     <= (snake_len > 7'(MAX_LEN)) ? 7'(MAX_LEN) : snake_len;
                    attempt <= attempt + 4'd1;
                    seg_idx <= '0;
                    rd_vld  <= 1'b0;
                    rd_last <= 1'b0;
                    iss     <= (snake_len != 7'd0);
                    state   <= (snake_len == 7'd0) ? DONE : SCAN;
                end
                SCAN: begin
                    rd_vld  <= iss;
                    rd_last <= last_iss;
                    if (iss) begin
                        if (last_iss) iss <= 1'b0;
                        else          seg_idx <= seg_idx + 6'd1;
                    end
                    // A hit drops any read still in flight and restarts from segment 0.
                    if (hit) begin
                        iss     <= 1'b0;
                        rd_vld  <= 1'b0;
                        seg_idx <= '0;
                        if (attempt == 4'(MAX_RETRY)) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            place_fail <= 1'b1;
                        end else begin
                            state <= SAMPLE;
                        end
                    end else if (rd_vld && rd_last) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    food_x     <= cand_x;
                    food_y     <= cand_y;
                    food_valid <= 1'b1;
                    busy       <= 1'b0;
                    iss        <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_food_placer.sv
// Directed bench for food_placer: table of clean placements plus collision, exhaustion, busy-drop and reset sequences.
module tb_food_placer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] rand_x;
    logic [8:0] rand_y;
    logic       place_req;
    logic [6:0] snake_len;
    logic [5:0] seg_idx;
    logic [9:0] seg_x;
    logic [8:0] seg_y;
    logic [9:0] food_x;
    logic [8:0] food_y;
    logic       food_valid;
    logic       busy;
    logic       place_fail;

    logic [9:0] body_x [64];
    logic [8:0] body_y [64];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Registered body RAM model: data follows the address by one cycle.
    always @(posedge clk) begin
        seg_x <= body_x[seg_idx];
        seg_y <= body_y[seg_idx];
    end

    food_placer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rand_x     (rand_x),
        .rand_y     (rand_y),
        .place_req  (place_req),
        .snake_len  (snake_len),
        .seg_idx    (seg_idx),
        .seg_x      (seg_x),
        .seg_y      (seg_y),
        .food_x     (food_x),
        .food_y     (food_y),
        .food_valid (food_valid),
        .busy       (busy),
        .place_fail (place_fail)
    );

    typedef struct {
        logic [9:0] rx;
        logic [8:0] ry;
        logic [6:0] len;
        logic [9:0] ex;
        logic [8:0] ey;
        int         lat;
    } tv_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Edge n is the n-th rising edge after place_req is raised; returns the edge where busy drops.
    task automatic run(input logic [9:0] rx, input logic [8:0] ry, input logic [6:0] len,
                       input int chg_n, input logic [9:0] rx2, input logic [8:0] ry2,
                       input int req_n, input int seg_n, output int n);
        @(negedge clk);
        rand_x    = rx;
        rand_y    = ry;
        snake_len = len;
        place_req = 1'b1;
        n = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            place_req = (n == req_n);
            if (n == chg_n) begin
                rand_x = rx2;
                rand_y = ry2;
            end
            if (n == 1) begin
                chk("busy_at_edge1", busy, 1);
                chk("valid_cleared_edge1", food_valid, 0);
                chk("fail_cleared_edge1", place_fail, 0);
            end
            if (seg_n > 0 && n >= 2 && n < 2 + seg_n)
                chk("seg_idx_seq", seg_idx, n - 2);
            if (!busy) break;
        end
        if (busy) chk("busy_timeout", busy, 0);
    endtask

    tv_t tv [7];
    int  n;
    int  busy_seen;

    initial begin
        tv[0] = '{rx: 10'd317,  ry: 9'd205, len: 7'd3,   ex: 10'd300, ey: 9'd200, lat: 7};
        tv[1] = '{rx: 10'd5,    ry: 9'd3,   len: 7'd3,   ex: 10'd20,  ey: 9'd20,  lat: 7};
        tv[2] = '{rx: 10'd619,  ry: 9'd459, len: 7'd3,   ex: 10'd600, ey: 9'd440, lat: 7};
        tv[3] = '{rx: 10'd1023, ry: 9'd511, len: 7'd0,   ex: 10'd600, ey: 9'd440, lat: 3};
        tv[4] = '{rx: 10'd140,  ry: 9'd119, len: 7'd2,   ex: 10'd140, ey: 9'd100, lat: 6};
        tv[5] = '{rx: 10'd41,   ry: 9'd39,  len: 7'd64,  ex: 10'd40,  ey: 9'd20,  lat: 68};
        tv[6] = '{rx: 10'd59,   ry: 9'd21,  len: 7'd100, ex: 10'd40,  ey: 9'd20,  lat: 68};

        for (int i = 0; i < 64; i++) begin
            body_x[i] = '0;
            body_y[i] = '0;
        end
        body_x[0] = 10'd100; body_y[0] = 9'd100;
        body_x[1] = 10'd120; body_y[1] = 9'd100;
        body_x[2] = 10'd140; body_y[2] = 9'd100;

        rst_n = 1'b0; rand_x = '0; rand_y = '0; place_req = 1'b0; snake_len = '0;
        repeat (3) @(negedge clk);
        chk("rst_food_x", food_x, 300);
        chk("rst_food_y", food_y, 200);
        chk("rst_food_valid", food_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_place_fail", place_fail, 0);
        chk("rst_seg_idx", seg_idx, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_release", busy, 0);

        for (int i = 0; i < 7; i++) begin
            run(tv[i].rx, tv[i].ry, tv[i].len, 0, '0, '0, 0,
                (tv[i].len > 64) ? 64 : int'(tv[i].len), n);
            chk("tv_latency", n, tv[i].lat);
            chk("tv_food_x", food_x, tv[i].ex);
            chk("tv_food_y", food_y, tv[i].ey);
            chk("tv_food_valid", food_valid, 1);
            chk("tv_place_fail", place_fail, 0);
        end

        // Collision at segment 1 on the first try, fresh candidate sampled in cycle 5.
        body_x[1] = 10'd300; body_y[1] = 9'd200;
        run(10'd317, 9'd205, 7'd3, 2, 10'd77, 9'd44, 0, 3, n);
        chk("coll_latency", n, 11);
        chk("coll_food_x", food_x, 60);
        chk("coll_food_y", food_y, 40);
        chk("coll_food_valid", food_valid, 1);
        body_x[1] = 10'd120; body_y[1] = 9'd100;

        // Every candidate hits segment 0: give up after 15 attempts.
        body_x[0] = 10'd300; body_y[0] = 9'd200;
        run(10'd317, 9'd205, 7'd3, 0, '0, '0, 0, 0, n);
        chk("exh_latency", n, 46);
        chk("exh_place_fail", place_fail, 1);
        chk("exh_food_valid", food_valid, 0);
        chk("exh_food_x_held", food_x, 60);
        chk("exh_food_y_held", food_y, 40);
        body_x[0] = 10'd100; body_y[0] = 9'd100;

        // Second request while busy is dropped, not queued.
        run(10'd5, 9'd3, 7'd3, 3, 10'd619, 9'd459, 3, 0, n);
        chk("drop_latency", n, 7);
        chk("drop_food_x", food_x, 20);
        chk("drop_food_y", food_y, 20);
        chk("drop_place_fail_cleared", place_fail, 0);
        busy_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        chk("drop_no_requeue", busy_seen, 0);

        // Reset in the middle of a scan.
        @(negedge clk);
        rand_x = 10'd317; rand_y = 9'd205; snake_len = 7'd3; place_req = 1'b1;
        @(negedge clk);
        place_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_scan_seg_idx", seg_idx, 1);
        chk("mid_scan_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_food_x", food_x, 300);
        chk("arst_food_y", food_y, 200);
        chk("arst_busy", busy, 0);
        chk("arst_seg_idx", seg_idx, 0);
        chk("arst_food_valid", food_valid, 0);
        repeat (3) @(negedge clk);
        chk("arst_hold_seg_idx", seg_idx, 0);
        rst_n = 1'b1;
        busy_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy || seg_idx != 6'd0) busy_seen++;
        end
        chk("arst_request_lost", busy_seen, 0);
        chk("arst_valid_after", food_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
